multicycle_control: RTL

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. It sits directly upstream of the ALU control decoder and supplies its 2-bit `ALU_Op`. Instruction and data memory share one port with a ready handshake, so fetch and memory states stall for wait states.

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable and mux select. Instruction and data memory share one port, so the
// memory-touching states hold until mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic [1:0] ALU_Op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_imm,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned StateW = 4;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Sr     = 3'b101;

  // FETCH is encoding 0 so the debug state reads 0 both in and after reset.
  typedef enum logic [StateW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t cur;

  // State register with next-state selection; unused encodings recover to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OpR:               cur <= S_EXEC_R;
            OpImm:             cur <= S_EXEC_I;
            OpLoad, OpStore:   cur <= S_MEM_ADDR;
            OpBranch:          cur <= S_BRANCH;
            OpJal:             cur <= S_JAL;
            default:           cur <= S_TRAP;
          endcase
        end
        S_EXEC_R:   cur <= S_ALU_WB;
        S_EXEC_I:   cur <= S_ALU_WB;
        S_ALU_WB:   cur <= S_FETCH;
        S_MEM_ADDR: cur <= (opcode == OpLoad) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) cur <= S_LOAD_WB;
        S_LOAD_WB:  cur <= S_FETCH;
        S_MEM_WR:   if (mem_ready) cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JAL:      cur <= S_FETCH;
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  // Output decode from the state register; everything forced low during reset
  // so an abandoned instruction cannot strobe a write in the reset cycle.
  always_comb begin
    ALU_Op        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_imm       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    illegal       = 1'b0;
    state         = '0;
    if (!rst) begin
      state = cur;
      case (cur)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          ALU_Op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          ALU_Op    = 2'b10;
          // Only the shift-right group uses funct7[5] as a real selector.
          alu_imm   = (funct3 != F3Sr);
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_LOAD_WB: begin
          reg_write = 1'b1;
          wb_sel    = 2'b01;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          ALU_Op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
        end
        S_JAL: begin
          reg_write = 1'b1;
          wb_sel    = 2'b10;
          pc_write  = 1'b1;
          pc_src    = 1'b1;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          state = cur;
        end
      endcase
    end
  end

endmodule
